// File: rtl/ysyx_25040111_csr_unit.sv
// Machine-mode CSR file with trap entry/return redirect generation.
// Optional mcycle/minstret counters are enabled by YSYX_25040111_CSR_COUNTER_EN.
module ysyx_25040111_csr_unit #(
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MVENDORID = 32'h79737978,
  parameter logic [31:0] MARCHID   = 32'd25040111
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_req,
  input  logic [3:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret_req,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  logic        mie_q, mpie_q;
  logic [31:2] mtvec_q, mepc_q;
  logic [31:0] mscratch_q, mcause_q;
  logic [31:0] mstatus_rd;
  logic        impl, ro, csr_we;
  logic [31:0] wval;

  // MPP is hardwired to machine mode; only MIE/MPIE are storage
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = trap_pc[1:0];

`ifdef YSYX_25040111_CSR_COUNTER_EN
  logic [CNT_W-1:0] mcycle_q, minstret_q;
  logic [63:0]      cyc64, ins64;
  assign cyc64 = 64'(mcycle_q);
  assign ins64 = 64'(minstret_q);
`else
  logic unused_retire;
  localparam int unused_cnt_w = CNT_W;
  assign unused_retire = instr_retire;
`endif

  always_comb begin
    impl      = 1'b1;
    ro        = 1'b0;
    csr_rdata = 32'h0;
    case (csr_addr)
      A_MSTATUS:   csr_rdata = mstatus_rd;
      A_MTVEC:     csr_rdata = {mtvec_q, 2'b00};
      A_MSCRATCH:  csr_rdata = mscratch_q;
      A_MEPC:      csr_rdata = {mepc_q, 2'b00};
      A_MCAUSE:    csr_rdata = mcause_q;
`ifdef YSYX_25040111_CSR_COUNTER_EN
      A_MCYCLE:    csr_rdata = cyc64[31:0];
      A_MCYCLEH:   csr_rdata = cyc64[63:32];
      A_MINSTRET:  csr_rdata = ins64[31:0];
      A_MINSTRETH: csr_rdata = ins64[63:32];
`endif
      A_MVENDORID: begin csr_rdata = MVENDORID; ro = 1'b1; end
      A_MARCHID:   begin csr_rdata = MARCHID;   ro = 1'b1; end
      default:     impl = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != OP_NONE) && (!impl || ro);
  // trap and mret each pre-empt any CSR access in the same cycle
  assign csr_we = (csr_op != OP_NONE) && !csr_illegal && !trap_req && !mret_req;

  always_comb begin
    case (csr_op)
      OP_WRITE: wval = csr_wdata;
      OP_SET:   wval = csr_rdata | csr_wdata;
      OP_CLR:   wval = csr_rdata & ~csr_wdata;
      default:  wval = csr_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mie_q          <= 1'b0;
      mpie_q         <= 1'b0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mscratch_q     <= '0;
      mcause_q       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= trap_req | mret_req;
      if (trap_req) begin
        mepc_q      <= trap_pc[31:2];
        mcause_q    <= {28'b0, trap_cause};
        mpie_q      <= mie_q;
        mie_q       <= 1'b0;
        redirect_pc <= {mtvec_q, 2'b00};
      end else if (mret_req) begin
        mie_q       <= mpie_q;
        mpie_q      <= 1'b1;
        redirect_pc <= {mepc_q, 2'b00};
      end else if (csr_we) begin
        case (csr_addr)
          A_MSTATUS:  begin mie_q <= wval[3]; mpie_q <= wval[7]; end
          A_MTVEC:    mtvec_q    <= wval[31:2];
          A_MSCRATCH: mscratch_q <= wval;
          A_MEPC:     mepc_q     <= wval[31:2];
          A_MCAUSE:   mcause_q   <= wval;
          default:    ;
        endcase
      end
    end
  end

`ifdef YSYX_25040111_CSR_COUNTER_EN
  // a write to either half replaces that cycle's increment for the whole counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && csr_addr == A_MCYCLE)
        mcycle_q <= CNT_W'({cyc64[63:32], wval});
      else if (csr_we && csr_addr == A_MCYCLEH)
        mcycle_q <= CNT_W'({wval, cyc64[31:0]});
      else
        mcycle_q <= mcycle_q + CNT_W'(1);

      if (csr_we && csr_addr == A_MINSTRET)
        minstret_q <= CNT_W'({ins64[63:32], wval});
      else if (csr_we && csr_addr == A_MINSTRETH)
        minstret_q <= CNT_W'({wval, ins64[31:0]});
      else if (instr_retire)
        minstret_q <= minstret_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/ysyx_25040111_csr_unit.md
YSYX_25040111_CSR_UNIT -- requirements
Module: ysyx_25040111_csr_unit

Interface
REQ-001 Parameter CNT_W, 64, counter width in bits (legal range 32..64).
REQ-002 Parameter MVENDORID, 32'h79737978, value returned at 0xF11.
REQ-003 Parameter MARCHID, 32'd25040111, value returned at 0xF12.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset: assertion clears state immediately, release is synchronous to clock.
REQ-006 csr_op  in  2  CSR operation: 00 none, 01 write, 10 set, 11 clear.
REQ-007 csr_addr  in  12  CSR address.
REQ-008 csr_wdata  in  32  CSR operand.
REQ-009 csr_rdata  out  32  combinational pre-update value at csr_addr; 0 for unimplemented addresses.
REQ-010 csr_illegal  out  1  combinational flag: csr_op!=00 and the address is unimplemented or read-only.
REQ-011 instr_retire  in  1  one instruction retired this cycle.
REQ-012 trap_req, trap_cause[3:0], trap_pc[31:0]  in  trap entry request, cause code, faulting PC.
REQ-013 mret_req  in  1  trap return request.
REQ-014 redirect_valid  out  1  registered one-cycle pulse; redirect_pc[31:0] out is valid with it.

Function
REQ-015 Implemented CSRs SHALL be mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00/mcycleh 0xB80, minstret 0xB02/minstreth 0xB82, mvendorid 0xF11 (RO), marchid 0xF12 (RO).
REQ-016 New value SHALL be wdata (01), old|wdata (10), or old&~wdata (11), committed at the next edge.
REQ-017 When csr_illegal=1, no CSR state SHALL change.
REQ-018 mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
REQ-019 mtvec[1:0] and mepc[1:0] SHALL always read 0 (direct mode, aligned).
REQ-020 Trap (trap_req=1): mepc<=trap_pc&~3, mcause<=zero-extended trap_cause, MPIE<=MIE, MIE<=0; next cycle redirect_valid=1, redirect_pc=mtvec.
REQ-021 mret (mret_req=1, trap_req=0): MIE<=MPIE, MPIE<=1; next cycle redirect_valid=1, redirect_pc=mepc value held in the request cycle.
REQ-022 Priority in one cycle: trap_req > mret_req > csr_op; a lower-priority request SHALL be dropped entirely.
REQ-023 redirect_valid SHALL be 0 in every cycle not immediately following an accepted trap or mret.
REQ-024 mcycle SHALL increment by 1 every cycle; minstret SHALL increment by 1 when instr_retire=1; both wrap from 2^CNT_W-1 to 0.
REQ-025 A CSR write to a counter half SHALL override that cycle's increment for the whole counter: the written half takes the new value and the other half holds.
REQ-026 Counter bits at or above CNT_W SHALL read 0 and ignore writes.

Reset
REQ-027 On reset_n=0: mstatus=0x00001800, mtvec=mscratch=mepc=mcause=0, counters=0, redirect_valid=0, redirect_pc=0.
REQ-028 A reset during a pending redirect SHALL suppress the pulse; the first post-release cycle has redirect_valid=0.

Configuration
REQ-029 Macro YSYX_25040111_CSR_COUNTER_EN: when defined, counters follow REQ-024..026.
REQ-030 When the macro is undefined, no counter registers exist, 0xB00/0xB80/0xB02/0xB82 are unimplemented (read 0, csr_illegal on any op), and instr_retire is ignored.

Verification
REQ-031 csr_op=01 to 0x305 with 0x80000007 -> next cycle read 0x80000004; csr_op=10 to 0x300 with 0x8 -> read 0x1808.
REQ-032 mtvec=0x80000100, MIE=1, trap_req with cause 11 and pc 0x80000022 -> next cycle redirect_valid=1, redirect_pc=0x80000100, mepc=0x80000020, mcause=11, mstatus=0x1880.
REQ-033 mret_req after REQ-032 -> redirect_pc=0x80000020, mstatus=0x1888.
REQ-034 trap_req, mret_req and csr write to 0x340 in the same cycle -> only the trap takes effect; mscratch unchanged.
REQ-035 Write 0xFFFFFFFF to 0xB00 and 0xB80 with CNT_W=64 -> mcycle wraps to 0 two cycles later; csr_op=01 to 0xF11 -> csr_illegal=1, read still 0x79737978.
REQ-036 Assert reset_n=0 mid-cycle after a trap accept -> outputs clear immediately, no redirect pulse after release; repeat REQ-035 with the macro undefined -> csr_illegal=1, read 0.
